// File: rtl/regfile_if.sv
// Bus bundle between the pipeline (decode/writeback/debug) and the register file.
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              we_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              re1_i;
    logic [ADDR_W-1:0] raddr1_i;
    logic [DATA_W-1:0] rdata1_o;
    logic              re2_i;
    logic [ADDR_W-1:0] raddr2_i;
    logic [DATA_W-1:0] rdata2_o;
    logic              dbg_req_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic              dbg_ack_o;
    logic [DATA_W-1:0] dbg_data_o;
    logic [CNT_W-1:0]  wr_cnt_o;

    modport master (
        output we_i, waddr_i, wdata_i,
        output re1_i, raddr1_i, re2_i, raddr2_i,
        output dbg_req_i, dbg_addr_i,
        input  rdata1_o, rdata2_o, dbg_ack_o, dbg_data_o, wr_cnt_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i,
        input  re1_i, raddr1_i, re2_i, raddr2_i,
        input  dbg_req_i, dbg_addr_i,
        output rdata1_o, rdata2_o, dbg_ack_o, dbg_data_o, wr_cnt_o
    );
endinterface

// File: rtl/regfile.sv
// 2R/1W register file with write-to-read bypass, $0 hardwired to zero,
// a req/ack debug read port and a retired-write counter.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32,
    parameter int CNT_W  = 32
) (
    input  logic       clk,
    input  logic       rst,
    regfile_if.slave   bus
);

    typedef enum logic [0:0] {
        DBG_IDLE = 1'b0,
        DBG_ACK  = 1'b1
    } dbg_state_e;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    dbg_state_e        state_q, state_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
    logic              wr_commit_s;
    logic [DATA_W-1:0] rdata1_s, rdata2_s;

    // Shared read rule: disabled or $0 reads give zero, a same-cycle write wins.
    function automatic logic [DATA_W-1:0] read_val(
        input logic              en,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] v;
        if (!en || (addr == {ADDR_W{1'b0}})) begin
            v = {DATA_W{1'b0}};
        end else if (we && (waddr == addr)) begin
            v = wdata;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // Read ports; held at zero while reset is asserted.
    always_comb begin
        rdata1_s = {DATA_W{1'b0}};
        rdata2_s = {DATA_W{1'b0}};
        if (!rst) begin
            rdata1_s = {DATA_W{1'b0}};
            rdata2_s = {DATA_W{1'b0}};
        end else begin
            rdata1_s = read_val(bus.re1_i, bus.raddr1_i, regs_q[bus.raddr1_i],
                                bus.we_i, bus.waddr_i, bus.wdata_i);
            rdata2_s = read_val(bus.re2_i, bus.raddr2_i, regs_q[bus.raddr2_i],
                                bus.we_i, bus.waddr_i, bus.wdata_i);
        end
    end

    // Writeback commit and retired-write counter.
    always_comb begin
        regs_d      = regs_q;
        wr_cnt_d    = wr_cnt_q;
        wr_commit_s = bus.we_i && (bus.waddr_i != {ADDR_W{1'b0}});
        if (wr_commit_s) begin
            regs_d[bus.waddr_i] = bus.wdata_i;
            wr_cnt_d            = wr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
        regs_d[0] = {DATA_W{1'b0}};
    end

    // Debug FSM: capture in IDLE, single ack cycle in ACK.
    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        dbg_data_d = dbg_data_q;
        case (state_q)
            DBG_IDLE: begin
                if (bus.dbg_req_i) begin
                    dbg_data_d = read_val(1'b1, bus.dbg_addr_i, regs_q[bus.dbg_addr_i],
                                          bus.we_i, bus.waddr_i, bus.wdata_i);
                    state_d    = DBG_ACK;
                    ack_d      = 1'b1;
                end else begin
                    state_d = DBG_IDLE;
                end
            end
            DBG_ACK: begin
                state_d = DBG_IDLE;
            end
            default: begin
                state_d = DBG_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            wr_cnt_q   <= {CNT_W{1'b0}};
            state_q    <= DBG_IDLE;
            ack_q      <= 1'b0;
            dbg_data_q <= {DATA_W{1'b0}};
        end else begin
            regs_q     <= regs_d;
            wr_cnt_q   <= wr_cnt_d;
            state_q    <= state_d;
            ack_q      <= ack_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    assign bus.rdata1_o   = rdata1_s;
    assign bus.rdata2_o   = rdata2_s;
    assign bus.dbg_ack_o  = ack_q;
    assign bus.dbg_data_o = dbg_data_q;
    assign bus.wr_cnt_o   = wr_cnt_q;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: reference model plus a scoreboard queue of
// expected debug captures, popped when the DUT acks.
module tb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic clk;
    logic rst;

    regfile_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    regfile #(.DATA_W(DW), .ADDR_W(AW), .NREG(32), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_regs [32];
    logic [CW-1:0] m_cnt;
    logic          m_ack;      // model FSM is in ACK state
    logic [DW-1:0] m_dbg;
    logic [DW-1:0] sbq [$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mread(input logic en, input logic [AW-1:0] a);
        if (!en || a == 5'd0) return 32'd0;
        if (bus.we_i && bus.waddr_i == a) return bus.wdata_i;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 4'd0;
        m_ack = 1'b0;
        m_dbg = 32'd0;
        sbq.delete();
    endtask

    task automatic idle_inputs();
        bus.we_i = 1'b0;  bus.waddr_i = 5'd0;  bus.wdata_i = 32'd0;
        bus.re1_i = 1'b0; bus.raddr1_i = 5'd0;
        bus.re2_i = 1'b0; bus.raddr2_i = 5'd0;
        bus.dbg_req_i = 1'b0; bus.dbg_addr_i = 5'd0;
    endtask

    // One clock: check outputs at negedge, advance the model at posedge.
    task automatic cycle();
        @(negedge clk);
        chk("rdata1", bus.rdata1_o, mread(bus.re1_i, bus.raddr1_i));
        chk("rdata2", bus.rdata2_o, mread(bus.re2_i, bus.raddr2_i));
        chk("dbg_ack", {31'd0, bus.dbg_ack_o}, {31'd0, m_ack});
        if (m_ack) begin
            if (sbq.size() == 0) begin
                chk("dbg_queue", 32'd1, 32'd0);
            end else begin
                m_dbg = sbq.pop_front();
            end
        end
        chk("dbg_data", bus.dbg_data_o, m_dbg);
        chk("wr_cnt", {28'd0, bus.wr_cnt_o}, {28'd0, m_cnt});
        @(posedge clk);
        if (!m_ack && bus.dbg_req_i) begin
            sbq.push_back(mread(1'b1, bus.dbg_addr_i));
            m_ack = 1'b1;
        end else begin
            m_ack = 1'b0;
        end
        if (bus.we_i && bus.waddr_i != 5'd0) begin
            m_regs[bus.waddr_i] = bus.wdata_i;
            m_cnt = m_cnt + 4'd1;
        end
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd1"}, bus.rdata1_o, 32'd0);
        chk({tag, "_rd2"}, bus.rdata2_o, 32'd0);
        chk({tag, "_ack"}, {31'd0, bus.dbg_ack_o}, 32'd0);
        chk({tag, "_dbg"}, bus.dbg_data_o, 32'd0);
        chk({tag, "_cnt"}, {28'd0, bus.wr_cnt_o}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] cnt_before;
        rst = 1'b0;
        idle_inputs();
        model_reset();
        bus.re1_i = 1'b1; bus.raddr1_i = 5'd3;
        bus.re2_i = 1'b1; bus.raddr2_i = 5'd9;
        #3;
        check_all_zero("init");
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Write r5, then read it back.
        idle_inputs();
        bus.we_i = 1'b1; bus.waddr_i = 5'd5; bus.wdata_i = 32'hDEADBEEF;
        cycle();
        idle_inputs();
        bus.re1_i = 1'b1; bus.raddr1_i = 5'd5;
        cycle();
        chk("r5_read", bus.rdata1_o, 32'hDEADBEEF);

        // Bypass on both ports.
        bus.we_i = 1'b1; bus.waddr_i = 5'd7; bus.wdata_i = 32'h12345678;
        bus.re1_i = 1'b1; bus.raddr1_i = 5'd7;
        bus.re2_i = 1'b1; bus.raddr2_i = 5'd7;
        #1;
        chk("bypass1", bus.rdata1_o, 32'h12345678);
        chk("bypass2", bus.rdata2_o, 32'h12345678);
        cycle();

        // $0 write discarded, not counted.
        cnt_before = m_cnt;
        bus.we_i = 1'b1; bus.waddr_i = 5'd0; bus.wdata_i = 32'hFFFFFFFF;
        bus.raddr1_i = 5'd0; bus.raddr2_i = 5'd0;
        cycle();
        bus.we_i = 1'b0;
        #1;
        chk("r0_read", bus.rdata1_o, 32'd0);
        chk("r0_cnt", {28'd0, bus.wr_cnt_o}, {28'd0, cnt_before});
        cycle();

        // Disabled read port.
        bus.re2_i = 1'b0; bus.raddr2_i = 5'd5;
        #1;
        chk("re2_off", bus.rdata2_o, 32'd0);
        cycle();

        // Single debug request, then a held request with changing address
        // and a same-register write during capture.
        idle_inputs();
        bus.dbg_req_i = 1'b1; bus.dbg_addr_i = 5'd5;
        cycle();
        bus.dbg_req_i = 1'b0;
        cycle();
        chk("dbg_r5", bus.dbg_data_o, 32'hDEADBEEF);
        cycle();
        bus.dbg_req_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr_i = 5'(i + 4);
            bus.we_i = 1'b1; bus.waddr_i = 5'(i + 4); bus.wdata_i = 32'hA000_0000 + 32'(i);
            cycle();
        end
        idle_inputs();
        cycle();
        cycle();

        // Randomised traffic with narrow addresses to force collisions.
        for (int i = 0; i < 300; i++) begin
            bus.we_i = 1'($urandom_range(0, 1));
            bus.waddr_i = 5'($urandom_range(0, 7));
            bus.wdata_i = $urandom;
            bus.re1_i = 1'($urandom_range(0, 3) != 0);
            bus.raddr1_i = 5'($urandom_range(0, 7));
            bus.re2_i = 1'($urandom_range(0, 3) != 0);
            bus.raddr2_i = 5'($urandom_range(0, 7));
            bus.dbg_req_i = 1'($urandom_range(0, 1));
            bus.dbg_addr_i = 5'($urandom_range(0, 7));
            cycle();
        end
        idle_inputs();
        cycle();
        cycle();

        // Counter wraps after 2**CW counted writes.
        cnt_before = m_cnt;
        for (int i = 0; i < 16; i++) begin
            bus.we_i = 1'b1; bus.waddr_i = 5'(1 + (i % 31)); bus.wdata_i = 32'(i * 3 + 1);
            cycle();
        end
        idle_inputs();
        #1;
        chk("cnt_wrap", {28'd0, bus.wr_cnt_o}, {28'd0, cnt_before});
        cycle();

        // Reset asserted while the FSM is in ACK: the ack is dropped.
        bus.we_i = 1'b1; bus.waddr_i = 5'd9; bus.wdata_i = 32'h5555AAAA;
        bus.dbg_req_i = 1'b1; bus.dbg_addr_i = 5'd9;
        cycle();
        idle_inputs();
        bus.re1_i = 1'b1; bus.raddr1_i = 5'd9;
        bus.re2_i = 1'b1; bus.raddr2_i = 5'd9;
        chk("pre_rst_ack", {31'd0, bus.dbg_ack_o}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Every register reads zero after reset.
        for (int i = 1; i < 32; i++) begin
            bus.re1_i = 1'b1; bus.raddr1_i = 5'(i);
            bus.re2_i = 1'b1; bus.raddr2_i = 5'(32 - i);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
